execute_stage: RTL and testbench

Execute stage of the 5-stage RV32IM core. Sits between decode/forwarding and the memory stage and computes the ALU result or RV32M multiply/divide result. Registers that result with the control fields the memory stage consumes into the EX/MEM pipeline register. Division is iterative, and the block back-pressures decode while a divide runs. It honours the memory stage's peripheral stall by holding EX/MEM.

---
 rtl/execute_stage.sv | 162 ++++++++++++++++
 tb/tb_execute_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of the RV32IM pipeline: ALU, single-cycle multiply, iterative
// restoring divide, and the EX/MEM pipeline register.
module execute_stage (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [3:0]  alu_op_i,
  input  logic        md_en_i,
  input  logic [2:0]  md_op_i,
  input  logic [31:0] rs2_value_i,
  input  logic [31:0] pc_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_label_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        reg_write_en_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic        load_store_forward_sel_i,
  input  logic        mem_stall_i,
  output logic        ex_stall_o,
  output logic [31:0] alu_result_mem_o,
  output logic [31:0] latest_rs2_value_mem_o,
  output logic [31:0] pc_mem_o,
  output logic [2:0]  funct3_mem_o,
  output logic [4:0]  rd_label_mem_o,
  output logic [1:0]  wb_sel_mem_o,
  output logic        reg_write_en_mem_o,
  output logic        is_load_mem_o,
  output logic        is_store_mem_o,
  output logic        load_store_forward_sel_mem_o
);
  // state | meaning
  // IDLE  | no divide in flight; ALU/MUL/fast-path results go straight to EX/MEM
  // DIV   | one restoring quotient bit per cycle, counter runs 31 down to 0
  // DONE  | sign-corrected divide result presented; waits out mem_stall_i
  typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_t;

  div_state_t  state;
  logic [4:0]  count;
  logic [31:0] quo;
  logic [32:0] rem;
  logic [31:0] divisor;
  logic        neg_q, neg_r, want_rem;

  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      4'd0:    alu_res = operand_a_i + operand_b_i;
      4'd1:    alu_res = operand_a_i - operand_b_i;
      4'd2:    alu_res = operand_a_i << operand_b_i[4:0];
      4'd3:    alu_res = {31'd0, $signed(operand_a_i) < $signed(operand_b_i)};
      4'd4:    alu_res = {31'd0, operand_a_i < operand_b_i};
      4'd5:    alu_res = operand_a_i ^ operand_b_i;
      4'd6:    alu_res = operand_a_i >> operand_b_i[4:0];
      4'd7:    alu_res = $unsigned($signed(operand_a_i) >>> operand_b_i[4:0]);
      4'd8:    alu_res = operand_a_i | operand_b_i;
      4'd9:    alu_res = operand_a_i & operand_b_i;
      4'd10:   alu_res = operand_b_i;
      default: alu_res = '0;
    endcase
  end

  // 33x33 signed product covers all four multiply flavours via the extension bit
  logic               mul_sa, mul_sb;
  logic signed [32:0] mul_a, mul_b;
  logic signed [65:0] mul_prod;
  logic [31:0]        mul_res;
  assign mul_sa   = (md_op_i == 3'd1) || (md_op_i == 3'd2);
  assign mul_sb   = (md_op_i == 3'd1);
  assign mul_a    = $signed({mul_sa & operand_a_i[31], operand_a_i});
  assign mul_b    = $signed({mul_sb & operand_b_i[31], operand_b_i});
  assign mul_prod = mul_a * mul_b;
  assign mul_res  = (md_op_i == 3'd0) ? mul_prod[31:0] : mul_prod[63:32];

  logic        div_op, div_signed, div_zero, div_ovf, div_start;
  logic [31:0] fast_res, div_res;
  assign div_op     = md_en_i & md_op_i[2];
  assign div_signed = ~md_op_i[0];
  assign div_zero   = (operand_b_i == 32'd0);
  assign div_ovf    = div_signed && (operand_a_i == 32'h8000_0000) && (operand_b_i == 32'hFFFF_FFFF);
  assign div_start  = (state == IDLE) && div_op && !div_zero && !div_ovf;
  assign ex_stall_o = div_start || (state == DIV);
  assign fast_res   = div_zero ? (md_op_i[1] ? operand_a_i : 32'hFFFF_FFFF)
                               : (md_op_i[1] ? 32'd0 : 32'h8000_0000);

  logic [32:0] rem_shift, rem_next;
  logic        rem_ge;
  assign rem_shift = {rem[31:0], quo[31]};
  assign rem_ge    = rem_shift >= {1'b0, divisor};
  assign rem_next  = rem_ge ? (rem_shift - {1'b0, divisor}) : rem_shift;
  assign div_res   = want_rem ? (neg_r ? -rem[31:0] : rem[31:0])
                              : (neg_q ? -quo : quo);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      want_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: if (div_start) begin
          state    <= DIV;
          count    <= 5'd31;
          quo      <= (div_signed & operand_a_i[31]) ? -operand_a_i : operand_a_i;
          divisor  <= (div_signed & operand_b_i[31]) ? -operand_b_i : operand_b_i;
          rem      <= '0;
          neg_q    <= div_signed & (operand_a_i[31] ^ operand_b_i[31]);
          neg_r    <= div_signed & operand_a_i[31];
          want_rem <= md_op_i[1];
        end
        DIV: begin
          rem <= rem_next;
          quo <= {quo[30:0], rem_ge};
          if (count == 5'd0) state <= DONE;
          else count <= count - 5'd1;
        end
        DONE: if (!mem_stall_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [31:0] ex_res;
  always_comb begin
    ex_res = alu_res;
    if (state == DONE) ex_res = div_res;
    else if (md_en_i) ex_res = md_op_i[2] ? fast_res : mul_res;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || (!mem_stall_i && ex_stall_o)) begin
      alu_result_mem_o             <= '0;
      latest_rs2_value_mem_o       <= '0;
      pc_mem_o                     <= '0;
      funct3_mem_o                 <= '0;
      rd_label_mem_o               <= '0;
      wb_sel_mem_o                 <= '0;
      reg_write_en_mem_o           <= 1'b0;
      is_load_mem_o                <= 1'b0;
      is_store_mem_o               <= 1'b0;
      load_store_forward_sel_mem_o <= 1'b0;
    end else if (!mem_stall_i) begin
      alu_result_mem_o             <= ex_res;
      latest_rs2_value_mem_o       <= rs2_value_i;
      pc_mem_o                     <= pc_i;
      funct3_mem_o                 <= funct3_i;
      rd_label_mem_o               <= rd_label_i;
      wb_sel_mem_o                 <= wb_sel_i;
      reg_write_en_mem_o           <= reg_write_en_i;
      is_load_mem_o                <= is_load_i;
      is_store_mem_o               <= is_store_i;
      load_store_forward_sel_mem_o <= load_store_forward_sel_i;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: cycle-level reference model compared every cycle,
// plus directed vectors with literal expected results.
`timescale 1ns/1ps
module tb_execute_stage;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic [31:0] operand_a_i, operand_b_i, rs2_value_i, pc_i;
  logic [3:0]  alu_op_i;
  logic        md_en_i;
  logic [2:0]  md_op_i, funct3_i;
  logic [4:0]  rd_label_i;
  logic [1:0]  wb_sel_i;
  logic        reg_write_en_i, is_load_i, is_store_i, load_store_forward_sel_i, mem_stall_i;
  logic        ex_stall_o;
  logic [31:0] alu_result_mem_o, latest_rs2_value_mem_o, pc_mem_o;
  logic [2:0]  funct3_mem_o;
  logic [4:0]  rd_label_mem_o;
  logic [1:0]  wb_sel_mem_o;
  logic        reg_write_en_mem_o, is_load_mem_o, is_store_mem_o, load_store_forward_sel_mem_o;

  always #5 clk_i = ~clk_i;

  execute_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .alu_op_i(alu_op_i), .md_en_i(md_en_i), .md_op_i(md_op_i),
    .rs2_value_i(rs2_value_i), .pc_i(pc_i), .funct3_i(funct3_i),
    .rd_label_i(rd_label_i), .wb_sel_i(wb_sel_i),
    .reg_write_en_i(reg_write_en_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .load_store_forward_sel_i(load_store_forward_sel_i), .mem_stall_i(mem_stall_i),
    .ex_stall_o(ex_stall_o),
    .alu_result_mem_o(alu_result_mem_o), .latest_rs2_value_mem_o(latest_rs2_value_mem_o),
    .pc_mem_o(pc_mem_o), .funct3_mem_o(funct3_mem_o), .rd_label_mem_o(rd_label_mem_o),
    .wb_sel_mem_o(wb_sel_mem_o), .reg_write_en_mem_o(reg_write_en_mem_o),
    .is_load_mem_o(is_load_mem_o), .is_store_mem_o(is_store_mem_o),
    .load_store_forward_sel_mem_o(load_store_forward_sel_mem_o)
  );

  int n_vec = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural result of one instruction, straight from the ISA definitions.
  function automatic logic [31:0] model_result(input logic md_en, input logic [2:0] md_op,
                                               input logic [3:0] alu_op, input logic [31:0] a, b);
    longint sp;
    longint unsigned up;
    int sa, sb;
    if (!md_en) begin
      case (alu_op)
        4'd0:  return a + b;
        4'd1:  return a - b;
        4'd2:  return a << b[4:0];
        4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        4'd4:  return (a < b) ? 32'd1 : 32'd0;
        4'd5:  return a ^ b;
        4'd6:  return a >> b[4:0];
        4'd7:  return $signed(a) >>> b[4:0];
        4'd8:  return a | b;
        4'd9:  return a & b;
        4'd10: return b;
        default: return 32'd0;
      endcase
    end
    sa = a;
    sb = b;
    case (md_op)
      3'd0: begin sp = longint'(sa) * longint'(sb); return sp[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
      3'd2: begin sp = longint'(sa) * longint'({32'd0, b}); return sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      default: ;
    endcase
    if (b == 32'd0) return md_op[1] ? a : 32'hFFFF_FFFF;
    if (!md_op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return md_op[1] ? 32'd0 : 32'h8000_0000;
      return md_op[1] ? (sa % sb) : (sa / sb);
    end
    return md_op[1] ? (a % b) : (a / b);
  endfunction

  function automatic bit slow_div(input logic md_en, input logic [2:0] md_op, input logic [31:0] a, b);
    if (!(md_en && md_op >= 3'd4) || b == 32'd0) return 1'b0;
    return !(!md_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Model state: stall cycles still owed by an in-flight divide, and "result ready".
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] e_res = '0, e_rs2 = '0, e_pc = '0;
  logic [2:0]  e_f3 = '0;
  logic [4:0]  e_rd = '0;
  logic [1:0]  e_wb = '0;
  logic        e_we = 1'b0, e_ld = 1'b0, e_st = 1'b0, e_fw = 1'b0;

  function automatic bit exp_stall();
    return (m_left > 0) || (!m_done && slow_div(md_en_i, md_op_i, operand_a_i, operand_b_i));
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_left = 0; m_done = 1'b0; m_res = '0;
      e_res = '0; e_rs2 = '0; e_pc = '0; e_f3 = '0; e_rd = '0; e_wb = '0;
      e_we = 1'b0; e_ld = 1'b0; e_st = 1'b0; e_fw = 1'b0;
    end else begin
      bit st;
      logic [31:0] r;
      st = exp_stall();
      r = m_done ? m_res : model_result(md_en_i, md_op_i, alu_op_i, operand_a_i, operand_b_i);
      if (!mem_stall_i) begin
        if (st) begin
          e_res = '0; e_rs2 = '0; e_pc = '0; e_f3 = '0; e_rd = '0; e_wb = '0;
          e_we = 1'b0; e_ld = 1'b0; e_st = 1'b0; e_fw = 1'b0;
        end else begin
          e_res = r; e_rs2 = rs2_value_i; e_pc = pc_i; e_f3 = funct3_i; e_rd = rd_label_i;
          e_wb = wb_sel_i; e_we = reg_write_en_i; e_ld = is_load_i; e_st = is_store_i;
          e_fw = load_store_forward_sel_i;
        end
      end
      if (st) begin
        if (m_left == 0) begin
          m_left = 32;
          m_res = model_result(md_en_i, md_op_i, alu_op_i, operand_a_i, operand_b_i);
        end else begin
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end
      end else if (m_done && !mem_stall_i) begin
        m_done = 1'b0;
      end
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge clk_i) begin
    if (cmp_on && !rst_i) begin
      chk("ex_stall", {31'd0, ex_stall_o}, {31'd0, exp_stall()});
      chk("alu_result", alu_result_mem_o, e_res);
      chk("rs2_value", latest_rs2_value_mem_o, e_rs2);
      chk("pc", pc_mem_o, e_pc);
      chk("ctrl", {17'd0, funct3_mem_o, rd_label_mem_o, wb_sel_mem_o, reg_write_en_mem_o,
                   is_load_mem_o, is_store_mem_o, load_store_forward_sel_mem_o},
                  {17'd0, e_f3, e_rd, e_wb, e_we, e_ld, e_st, e_fw});
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_common();
    pc_i = pc_i + 32'd4;
    rs2_value_i = pc_i ^ 32'h5A5A_0000;
    funct3_i = pc_i[4:2];
    rd_label_i = pc_i[6:2];
    wb_sel_i = pc_i[3:2];
    reg_write_en_i = 1'b1;
    is_load_i = pc_i[2];
    is_store_i = pc_i[3];
    load_store_forward_sel_i = pc_i[4];
  endtask

  task automatic set_alu(input logic [3:0] op, input logic [31:0] a, b);
    set_common();
    md_en_i = 1'b0; md_op_i = 3'd0; alu_op_i = op; operand_a_i = a; operand_b_i = b;
  endtask

  task automatic set_md(input logic [2:0] op, input logic [31:0] a, b);
    set_common();
    md_en_i = 1'b1; md_op_i = op; alu_op_i = 4'd0; operand_a_i = a; operand_b_i = b;
  endtask

  task automatic run_alu(input string name, input logic [3:0] op, input logic [31:0] a, b, exp);
    set_alu(op, a, b);
    tick();
    chk(name, alu_result_mem_o, exp);
  endtask

  task automatic run_md_fast(input string name, input logic [2:0] op, input logic [31:0] a, b, exp);
    set_md(op, a, b);
    #1 chk({name, "_nostall"}, {31'd0, ex_stall_o}, 32'd0);
    tick();
    chk(name, alu_result_mem_o, exp);
  endtask

  task automatic run_div(input string name, input logic [2:0] op, input logic [31:0] a, b, exp);
    int stalls = 0, bubbles = 0, cyc = 0;
    bit got = 1'b0;
    set_md(op, a, b);
    while (cyc < 60 && !got) begin
      @(negedge clk_i);
      if (ex_stall_o) stalls++;
      tick();
      cyc++;
      if (reg_write_en_mem_o) got = 1'b1;
      else bubbles++;
    end
    chk({name, "_captured"}, {31'd0, got}, 32'd1);
    chk({name, "_stall_cycles"}, stalls, 32'd33);
    chk({name, "_bubbles"}, bubbles, 32'd33);
    chk(name, alu_result_mem_o, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    operand_a_i = '0; operand_b_i = '0; alu_op_i = '0; md_en_i = 1'b0; md_op_i = '0;
    rs2_value_i = '0; pc_i = 32'h0000_1000; funct3_i = '0; rd_label_i = '0; wb_sel_i = '0;
    reg_write_en_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
    load_store_forward_sel_i = 1'b0; mem_stall_i = 1'b0;
    repeat (2) tick();
    chk("reset_result", alu_result_mem_o, 32'd0);
    chk("reset_we", {31'd0, reg_write_en_mem_o}, 32'd0);
    chk("reset_stall", {31'd0, ex_stall_o}, 32'd0);
    rst_i = 1'b0;
    cmp_on = 1'b1;
    tick();

    run_alu("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    run_alu("sra", 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000);
    run_alu("sltu", 4'd4, 32'h1, 32'hFFFF_FFFF, 32'd1);
    run_alu("slt", 4'd3, 32'h1, 32'hFFFF_FFFF, 32'd0);
    run_alu("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    run_alu("sll", 4'd2, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030);
    run_alu("srl", 4'd6, 32'h8000_0000, 32'd31, 32'h1);
    run_alu("xor", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    run_alu("or", 4'd8, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
    run_alu("and", 4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    run_alu("pass_b", 4'd10, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000);
    run_alu("op12", 4'd12, 32'h1234_5678, 32'hABCD_E000, 32'd0);

    run_md_fast("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    run_md_fast("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_md_fast("mul", 3'd0, 32'd6, 32'd7, 32'd42);
    run_md_fast("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);

    // memory-stage stall holds EX/MEM over a plain ALU op
    set_alu(4'd0, 32'd1, 32'd2);
    mem_stall_i = 1'b1;
    tick();
    chk("hold_alu", alu_result_mem_o, 32'hFFFF_FFFF);
    mem_stall_i = 1'b0;
    tick();
    chk("release_alu", alu_result_mem_o, 32'd3);

    run_md_fast("div_by_0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_md_fast("remu_by_0", 3'd7, 32'd5, 32'd0, 32'd5);
    run_md_fast("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_md_fast("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    run_div("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14);
    run_div("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2);
    run_div("div_100_m7", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);

    // divide result held in DONE by three stalled cycles
    set_md(3'd5, 32'd1000, 32'd10);
    repeat (33) tick();
    mem_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_hold_we", {31'd0, reg_write_en_mem_o}, 32'd0);
    end
    mem_stall_i = 1'b0;
    tick();
    chk("done_release", alu_result_mem_o, 32'd100);
    chk("done_release_we", {31'd0, reg_write_en_mem_o}, 32'd1);

    // reset in the middle of a divide
    set_md(3'd4, 32'd12345, 32'd17);
    repeat (10) tick();
    rst_i = 1'b1;
    md_en_i = 1'b0;
    reg_write_en_i = 1'b0;
    #1;
    chk("rst_mid_result", alu_result_mem_o, 32'd0);
    chk("rst_mid_pc", pc_mem_o, 32'd0);
    chk("rst_mid_we", {31'd0, reg_write_en_mem_o}, 32'd0);
    chk("rst_mid_stall", {31'd0, ex_stall_o}, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    run_alu("post_rst_add", 4'd0, 32'd40, 32'd2, 32'd42);
    run_div("post_rst_div", 3'd4, 32'd12345, 32'd17, 32'd726);

    set_alu(4'd0, 32'd0, 32'd0);
    tick();
    cmp_on = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
